pipe_add_unit: RTL and testbench



---
 rtl/pipe_add_unit.sv | 153 +++++++++++++++
 tb/tb_pipe_add_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_unit.sv
// pipe_add_unit: two-stage pipelined adder/subtractor with an internal accumulator.
//
// Stage 1 registers the operand beat (a, b, op). Stage 2 computes the result and flags from
// stage 1 and registers them. The accumulator is read and written only when a beat moves from
// stage 1 into stage 2, so back-to-back ACC beats see each other's updates.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready is combinational from out_ready)
//   a, b, op             operands and opcode (00 ADD, 01 SUB, 10 ACC, 11 CLR)
//   out_valid/out_ready  result handshake
//   result, carry,       registered result, carry-out/borrow and two's-complement overflow
//   overflow
//
// Build option: define PIPE_ADD_SAT_EN to clamp overflowing results (and the accumulator) to
// the signed max/min instead of wrapping.
module pipe_add_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAcc = 2'b10,
    OpClr = 2'b11
  } op_e;

  // Stage 1
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;

  // Stage 2 (output)
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             overflow_q;

  logic [WIDTH-1:0] acc_q;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;

  // ACC reuses the adder with the accumulator as the left operand and a as the right one.
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  always_comb begin
    lhs = (s1_op_q == OpAcc) ? acc_q : s1_a_q;
    rhs = (s1_op_q == OpAcc) ? s1_a_q : s1_b_q;
  end

  assign sum_ext  = {1'b0, lhs} + {1'b0, rhs};
  // Bit WIDTH of the extended difference is set exactly when lhs < rhs (borrow).
  assign diff_ext = {1'b0, lhs} - {1'b0, rhs};

  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ov_d;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ov_d    = 1'b0;
    case (s1_op_q)
      OpAdd, OpAcc: begin
        res_d   = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
        ov_d    = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum_ext[WIDTH-1] != lhs[WIDTH-1]);
      end
      OpSub: begin
        res_d   = diff_ext[WIDTH-1:0];
        carry_d = diff_ext[WIDTH];
        ov_d    = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (diff_ext[WIDTH-1] != lhs[WIDTH-1]);
      end
      default: begin
        res_d   = '0;
        carry_d = 1'b0;
        ov_d    = 1'b0;
      end
    endcase
`ifdef PIPE_ADD_SAT_EN
    // On overflow the true result always has the sign of the left operand.
    if (ov_d) begin
      res_d = lhs[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OpAdd;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q  <= a;
          s1_b_q  <= b;
          s1_op_q <= op_e'(op);
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q   <= res_d;
          carry_q    <= carry_d;
          overflow_q <= ov_d;
        end
      end
      if (s1_adv) begin
        if (s1_op_q == OpAcc) begin
          acc_q <= res_d;
        end else if (s1_op_q == OpClr) begin
          acc_q <= '0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipe_add_unit.sv
// Self-checking bench for pipe_add_unit (WIDTH=4). Expected beats are pushed to a scoreboard
// when the DUT accepts them and popped when the DUT presents a result.
module tb_pipe_add_unit;

  localparam int W = 4;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  pipe_add_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_beat: got result=%b c=%b v=%b, required no beat",
                 result, carry, overflow);
      end else begin
        mon_e = sb.pop_front();
        if ({result, carry, overflow} !== {mon_e.r, mon_e.c, mon_e.v}) begin
          mismatched++;
          $display("FAIL beat_value: got result=%b c=%b v=%b, required result=%b c=%b v=%b",
                   result, carry, overflow, mon_e.r, mon_e.c, mon_e.v);
        end
        if (mon_e.lat) begin
          compared++;
          if (cyc - mon_e.cyc != 2) begin
            mismatched++;
            $display("FAIL latency: got %0d cycles, required 2", cyc - mon_e.cyc);
          end
        end
      end
    end
  end

  // Offers one beat and waits (bounded) for acceptance; pushes the expected result on accept.
  task automatic drive(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ec, input logic ev, input bit lat);
    exp_t e;
    int   n;
    n        = 0;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required acceptance");
      in_valid = 1'b0;
    end else begin
      e.r   = er;
      e.c   = ec;
      e.v   = ev;
      e.cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
      n_acc++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    compared++;
    if ({out_valid, result, carry, overflow} !== {1'b0, 4'b0000, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b r=%b c=%b ov=%b, required 0 0000 0 0",
               out_valid, result, carry, overflow);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] dummy;
    dummy     = '0;
    out_ready = 1'b0;
    drive(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0);
    drive(ACC, 4'b0101, dummy, 4'b0101, 1'b0, 1'b0, 1'b0);
    // ADD now held in stage 2, ACC held in stage 1.
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, result, carry, overflow} !== {1'b0, 4'b0000, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL midreset_outputs: got v=%b r=%b c=%b ov=%b, required 0 0000 0 0",
               out_valid, result, carry, overflow);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_in_ready: got %b, required 1", in_ready);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL stale_beat: got out_valid=%b at cycle %0d after reset, required 0",
                 out_valid, i);
      end
    end
    @(posedge clk);
    #1;
    // Accumulator must be 0: the ACC that sat in stage 1 never committed.
    drive(ACC, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    wait_drain("reset_acc");
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(ADD, 4'b0100, 4'b0010, 4'b0110, 1'b0, 1'b0, 1'b1);
    drive(ADD, 4'b0110, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b1);
    wait_drain("b2b");
  endtask

  task automatic test_overflow;
    out_ready = 1'b1;
`ifdef PIPE_ADD_SAT_EN
    drive(ADD, 4'b0111, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1);
    drive(SUB, 4'b0010, 4'b0100, 4'b1110, 1'b1, 1'b0, 1'b1);
    drive(SUB, 4'b1000, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1);
`else
    drive(ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b1);
    drive(SUB, 4'b0010, 4'b0100, 4'b1110, 1'b1, 1'b0, 1'b1);
    drive(SUB, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1);
`endif
    wait_drain("overflow");
  endtask

  task automatic test_accumulate;
    out_ready = 1'b1;
    drive(CLR, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
    drive(ACC, 4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b0, 1'b1);
    drive(ACC, 4'b0010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b1);
    drive(ACC, 4'b0001, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b1);
    drive(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1);
    drive(ACC, 4'b0001, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b1);
    // 0111 + 0001 overflows; with saturation the accumulator keeps 0111.
`ifdef PIPE_ADD_SAT_EN
    drive(ACC, 4'b0001, 4'b0000, 4'b0111, 1'b0, 1'b1, 1'b1);
    drive(ACC, 4'b0000, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b1);
`else
    drive(ACC, 4'b0001, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1);
    drive(ACC, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1);
`endif
    wait_drain("accumulate");
  endtask

  task automatic test_backpressure;
    logic [W+1:0] snap;
    int           base;
    out_ready = 1'b0;
    base      = n_acc;
    fork
      begin
        drive(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0);
        drive(ADD, 4'b0011, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b0);
        drive(ADD, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0);
        drive(ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL bp_in_ready: got %b with both stages full, required 0", in_ready);
        end
        compared++;
        if (n_acc - base != 2) begin
          mismatched++;
          $display("FAIL bp_accepted: got %0d beats accepted, required 2", n_acc - base);
        end
        snap = {out_valid, result, carry};
        repeat (2) @(negedge clk);
        compared++;
        if ({out_valid, result, carry, overflow} !== {snap, 1'b0}) begin
          mismatched++;
          $display("FAIL bp_hold: got v=%b r=%b c=%b ov=%b, required v=%b r=%b c=%b ov=0",
                   out_valid, result, carry, overflow, snap[W+1], snap[W:1], snap[0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
    compared++;
    if (n_acc - base != 4) begin
      mismatched++;
      $display("FAIL bp_total: got %0d beats accepted, required 4", n_acc - base);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_back_to_back();
    test_overflow();
    test_accumulate();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
